alu_issue_ctrl: RTL and testbench

Registered, handshaked successor to the combinational ALU control decoder. Decodes `aluop`/`funct7`/`funct3` into a 5-bit-or-wider ALU operation code covering the full RV32I ALU set. Optionally covers the M extension, issuing M-extension ops to an iterative mul/div unit and waiting for its completion under a timeout. Sits between the main control unit and the ALU/mul-div datapath in the execute stage.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_op_decode.sv | 55 +++++
 rtl/alu_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: op codes, aluop encodings,
// funct7 patterns, the FSM state type and the base funct3 op map.
package alu_pkg;

  localparam logic [4:0] ALU_AND    = 5'b00000;
  localparam logic [4:0] ALU_OR     = 5'b00001;
  localparam logic [4:0] ALU_ADD    = 5'b00010;
  localparam logic [4:0] ALU_XOR    = 5'b00011;
  localparam logic [4:0] ALU_SLL    = 5'b00100;
  localparam logic [4:0] ALU_SRL    = 5'b00101;
  localparam logic [4:0] ALU_SUB    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_SLT    = 5'b01000;
  localparam logic [4:0] ALU_SLTU   = 5'b01001;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic {
    ST_IDLE,
    ST_MD_WAIT
  } alu_state_t;

  function automatic logic [4:0] base_op(input logic [2:0] funct3);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of {aluop, funct7, funct3} into an ALU op code.
// M-extension decode is present only when ALU_ISSUE_MEXT_EN is defined.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [4:0] op,
  output logic       illegal,
  output logic       is_md
);

  always_comb begin
    op      = ALU_ADD;
    illegal = 1'b0;
    is_md   = 1'b0;
    case (aluop)
      ALUOP_MEM: op = ALU_ADD;
      ALUOP_BR:  op = ALU_SUB;
      ALUOP_R: begin
        if (funct7 == F7_BASE) begin
          op = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          op = ALU_SRA;
`ifdef ALU_ISSUE_MEXT_EN
        end else if (funct7 == F7_MEXT) begin
          op    = {2'b10, funct3};
          is_md = 1'b1;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        // I-type: funct7 is really imm[11:5], meaningful only for shifts
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) op = ALU_SLL;
            else                   illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     op = ALU_SRL;
            else if (funct7 == F7_ALT) op = ALU_SRA;
            else                       illegal = 1'b1;
          end
          default: op = base_op(funct3);
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Registered, handshaked ALU control decoder with optional mul/div issue.
// Define ALU_ISSUE_MEXT_EN to enable M-extension issue, MD_WAIT and the timeout.
//
//  state      | meaning
//  ST_IDLE    | accepting requests; output register drains via out_ready
//  ST_MD_WAIT | mul/div op issued, waiting for md_done or timeout
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int OPW        = 5,
  parameter int MD_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     aluop,
  input  logic [6:0]     funct7,
  input  logic [2:0]     funct3,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] aluoperation,
  output logic           illegal,
  output logic           md_timeout,
  output logic           md_start,
  output logic [2:0]     md_op,
  input  logic           md_done
);

  logic [4:0] dec_op;
  logic       dec_illegal;
  logic       dec_is_md;

  alu_op_decode u_dec (
    .aluop   (aluop),
    .funct7  (funct7),
    .funct3  (funct3),
    .op      (dec_op),
    .illegal (dec_illegal),
    .is_md   (dec_is_md)
  );

  alu_state_t     state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [OPW-1:0] aluop_q, aluop_d;
  logic           illegal_q, illegal_d;
  logic           accept;

`ifdef ALU_ISSUE_MEXT_EN
  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_start_q, md_start_d;
  logic [2:0]       md_op_q, md_op_d;
  logic             md_timeout_q, md_timeout_d;
`else
  logic unused_md;
  assign unused_md = dec_is_md ^ md_done ^ (MD_TIMEOUT > 0);
`endif

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    aluop_d      = aluop_q;
    illegal_d    = illegal_q;
`ifdef ALU_ISSUE_MEXT_EN
    cnt_d        = cnt_q;
    md_start_d   = 1'b0;
    md_op_d      = md_op_q;
    md_timeout_d = md_timeout_q;
`endif
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      illegal_d   = 1'b0;
`ifdef ALU_ISSUE_MEXT_EN
      cnt_d        = '0;
      md_timeout_d = 1'b0;
`endif
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
`ifdef ALU_ISSUE_MEXT_EN
            if (dec_is_md) begin
              state_d    = ST_MD_WAIT;
              md_start_d = 1'b1;
              md_op_d    = funct3;
              cnt_d      = '0;
            end else begin
              md_timeout_d = 1'b0;
`else
            begin
`endif
              out_valid_d = 1'b1;
              aluop_d     = OPW'(dec_op);
              illegal_d   = dec_illegal;
            end
          end
        end
`ifdef ALU_ISSUE_MEXT_EN
        ST_MD_WAIT: begin
          // md_done on the expiry cycle takes precedence over the timeout
          if (md_done || cnt_q == CNT_MAX) begin
            state_d      = ST_IDLE;
            out_valid_d  = 1'b1;
            aluop_d      = OPW'({2'b10, md_op_q});
            illegal_d    = 1'b0;
            md_timeout_d = !md_done;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      aluop_q      <= '0;
      illegal_q    <= 1'b0;
`ifdef ALU_ISSUE_MEXT_EN
      cnt_q        <= '0;
      md_start_q   <= 1'b0;
      md_op_q      <= 3'b000;
      md_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      aluop_q      <= aluop_d;
      illegal_q    <= illegal_d;
`ifdef ALU_ISSUE_MEXT_EN
      cnt_q        <= cnt_d;
      md_start_q   <= md_start_d;
      md_op_q      <= md_op_d;
      md_timeout_q <= md_timeout_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign aluoperation = aluop_q;
  assign illegal      = illegal_q;

`ifdef ALU_ISSUE_MEXT_EN
  assign md_start   = md_start_q;
  assign md_op      = md_op_q;
  assign md_timeout = md_timeout_q;
`else
  assign md_start   = 1'b0;
  assign md_op      = 3'b000;
  assign md_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed + randomized bench for alu_issue_ctrl against a behavioural model.
module tb_alu_issue_ctrl;

  localparam int OPW = 5;
  localparam int TMO = 8;
`ifdef ALU_ISSUE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       md_done = 1'b0;
  logic [1:0] aluop = 2'b00;
  logic [6:0] funct7 = 7'd0;
  logic [2:0] funct3 = 3'd0;

  logic           in_ready, out_valid, illegal, md_timeout, md_start;
  logic [OPW-1:0] aluoperation;
  logic [2:0]     md_op;

  int checks = 0;
  int errors = 0;

  // RV32I funct3 -> op code for the plain (funct7 = 0) encodings
  logic [4:0] base_tab [8] = '{5'b00010, 5'b00100, 5'b01000, 5'b01001,
                               5'b00011, 5'b00101, 5'b00001, 5'b00000};

  always #5 clk = ~clk;

  alu_issue_ctrl #(.OPW(OPW), .MD_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .aluop        (aluop),
    .funct7       (funct7),
    .funct3       (funct3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .aluoperation (aluoperation),
    .illegal      (illegal),
    .md_timeout   (md_timeout),
    .md_start     (md_start),
    .md_op        (md_op),
    .md_done      (md_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [6:0] f7,
                       input logic [2:0] f3);
    in_valid = v;
    aluop    = a;
    funct7   = f7;
    funct3   = f3;
  endtask

  function automatic void ref_dec(input logic [1:0] a, input logic [6:0] f7,
                                  input logic [2:0] f3, output logic [4:0] op,
                                  output logic ill, output logic md);
    op  = 5'b00010;
    ill = 1'b0;
    md  = 1'b0;
    if (a == 2'd0)      op = 5'b00010;
    else if (a == 2'd1) op = 5'b00110;
    else if (a == 2'd2) begin
      if (f7 == 7'h00)                     op = base_tab[f3];
      else if (f7 == 7'h20 && f3 == 3'd0)  op = 5'b00110;
      else if (f7 == 7'h20 && f3 == 3'd5)  op = 5'b00111;
      else if (f7 == 7'h01 && MEXT) begin  op = {2'b10, f3}; md = 1'b1; end
      else                                 ill = 1'b1;
    end else begin
      if (f3 == 3'd1 && f7 != 7'h00)       ill = 1'b1;
      else if (f3 == 3'd5 && f7 == 7'h20)  op = 5'b00111;
      else if (f3 == 3'd5 && f7 != 7'h00)  ill = 1'b1;
      else                                 op = base_tab[f3];
    end
    if (ill) op = 5'b00010;
  endfunction

  initial begin
    logic       exp_valid, exp_ill, exp_md, acc;
    logic [4:0] exp_op;
    logic [6:0] f7_pick [4];

    // reset
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_md_timeout", 32'(md_timeout), 0);
    chk("rst_md_start", 32'(md_start), 0);
    chk("rst_aluoperation", 32'(aluoperation), 0);
    chk("rst_md_op", 32'(md_op), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // R-type SUB
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 7'h20, 3'd0);
    tick();
    drive(1'b0, 2'b00, 7'h00, 3'd0);
    chk("sub_valid", 32'(out_valid), 1);
    chk("sub_op", 32'(aluoperation), 32'b00110);
    chk("sub_illegal", 32'(illegal), 0);

    // back-to-back AND, OR, SRA
    drive(1'b1, 2'b10, 7'h00, 3'd7);
    tick();
    chk("b2b_and", 32'(aluoperation), 32'b00000);
    drive(1'b1, 2'b10, 7'h00, 3'd6);
    tick();
    chk("b2b_or", 32'(aluoperation), 32'b00001);
    drive(1'b1, 2'b10, 7'h20, 3'd5);
    tick();
    chk("b2b_sra", 32'(aluoperation), 32'b00111);
    chk("b2b_valid", 32'(out_valid), 1);

    // backpressure: result holds, request refused
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 7'h00, 3'd7);
    #1;
    chk("bp_in_ready", 32'(in_ready), 0);
    tick();
    chk("bp_hold_valid", 32'(out_valid), 1);
    chk("bp_hold_op", 32'(aluoperation), 32'b00111);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    tick();
    chk("bp_next_op", 32'(aluoperation), 32'b00000);
    drive(1'b0, 2'b00, 7'h00, 3'd0);
    tick();
    chk("drain_valid", 32'(out_valid), 0);

    // I-type SLLI with bad imm[11:5]
    drive(1'b1, 2'b11, 7'h20, 3'd1);
    tick();
    drive(1'b0, 2'b00, 7'h00, 3'd0);
    chk("islli_illegal", 32'(illegal), 1);
    chk("islli_op", 32'(aluoperation), 32'b00010);

    // flush blocks a same-cycle request and clears the result
    flush = 1'b1;
    drive(1'b1, 2'b10, 7'h00, 3'd4);
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 7'h00, 3'd0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_illegal", 32'(illegal), 0);

    // randomized non-MD traffic with backpressure
    f7_pick = '{7'h00, 7'h20, 7'h01, 7'h00};
    exp_valid = 1'b0;
    exp_op = 5'd0;
    exp_ill = 1'b0;
    for (int i = 0; i < 300; i++) begin
      funct7 = f7_pick[$urandom_range(3)];
      if ($urandom_range(7) == 0) funct7 = 7'($urandom);
      aluop  = 2'($urandom);
      funct3 = 3'($urandom);
      if (MEXT && aluop == 2'b10 && funct7 == 7'h01) funct7 = 7'h02;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      #1;
      chk("rnd_in_ready", 32'(in_ready), 32'(!exp_valid || out_ready));
      acc = in_valid && (!exp_valid || out_ready);
      if (acc) begin
        ref_dec(aluop, funct7, funct3, exp_op, exp_ill, exp_md);
        exp_valid = 1'b1;
      end else if (out_ready) begin
        exp_valid = 1'b0;
      end
      tick();
      chk("rnd_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("rnd_op", 32'(aluoperation), 32'(exp_op));
        chk("rnd_illegal", 32'(illegal), 32'(exp_ill));
      end
      chk("rnd_md_start", 32'(md_start), 0);
    end
    drive(1'b0, 2'b00, 7'h00, 3'd0);
    out_ready = 1'b1;
    tick();
    chk("rnd_drain", 32'(out_valid), 0);

`ifdef ALU_ISSUE_MEXT_EN
    // MUL completes 5 cycles after issue
    drive(1'b1, 2'b10, 7'h01, 3'd0);
    tick();
    drive(1'b0, 2'b00, 7'h00, 3'd0);
    chk("mul_start", 32'(md_start), 1);
    chk("mul_md_op", 32'(md_op), 0);
    chk("mul_in_ready", 32'(in_ready), 0);
    tick();
    chk("mul_start_pulse", 32'(md_start), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mul_wait_valid", 32'(out_valid), 0);
    end
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    chk("mul_valid", 32'(out_valid), 1);
    chk("mul_op", 32'(aluoperation), 32'b10000);
    chk("mul_timeout", 32'(md_timeout), 0);
    tick();
    chk("mul_drain", 32'(out_valid), 0);

    // DIV with no md_done times out at accept+TMO+1
    drive(1'b1, 2'b10, 7'h01, 3'd4);
    tick();
    drive(1'b0, 2'b00, 7'h00, 3'd0);
    chk("div_md_op", 32'(md_op), 4);
    for (int k = 1; k < TMO; k++) begin
      tick();
      chk("div_wait_valid", 32'(out_valid), 0);
    end
    tick();
    chk("div_edge_tmo_valid", 32'(out_valid), 0);
    tick();
    chk("div_tmo_valid", 32'(out_valid), 1);
    chk("div_tmo_flag", 32'(md_timeout), 1);
    chk("div_tmo_illegal", 32'(illegal), 0);
    tick();

    // md_done on the expiry cycle wins over the timeout
    drive(1'b1, 2'b10, 7'h01, 3'd4);
    tick();
    drive(1'b0, 2'b00, 7'h00, 3'd0);
    for (int k = 0; k < TMO; k++) tick();
    chk("div2_wait_valid", 32'(out_valid), 0);
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    chk("div2_valid", 32'(out_valid), 1);
    chk("div2_tmo_flag", 32'(md_timeout), 0);
    chk("div2_op", 32'(aluoperation), 32'b10100);
    tick();

    // flush during MD_WAIT, later md_done ignored
    drive(1'b1, 2'b10, 7'h01, 3'd6);
    tick();
    drive(1'b0, 2'b00, 7'h00, 3'd0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    chk("fl_md_valid", 32'(out_valid), 0);
    chk("fl_md_in_ready", 32'(in_ready), 1);
    tick();
    chk("fl_md_valid2", 32'(out_valid), 0);

    // async reset mid-wait
    drive(1'b1, 2'b10, 7'h01, 3'd3);
    tick();
    drive(1'b0, 2'b00, 7'h00, 3'd0);
    chk("ar_start", 32'(md_start), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_md_start", 32'(md_start), 0);
    chk("ar_md_op", 32'(md_op), 0);
    chk("ar_valid", 32'(out_valid), 0);
    md_done = 1'b1;
    tick();
    rst_n = 1'b1;
    md_done = 1'b0;
    tick();
    chk("ar_late_done", 32'(out_valid), 0);
    chk("ar_in_ready", 32'(in_ready), 1);
`else
    // M-extension encodings decode illegal and never start the mul/div unit
    drive(1'b1, 2'b10, 7'h01, 3'd0);
    tick();
    drive(1'b0, 2'b00, 7'h00, 3'd0);
    chk("nomext_illegal", 32'(illegal), 1);
    chk("nomext_op", 32'(aluoperation), 32'b00010);
    chk("nomext_start", 32'(md_start), 0);
    chk("nomext_in_ready", 32'(in_ready), 1);
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    chk("nomext_done_ignored", 32'(out_valid), 0);
    rst_n = 1'b0;
    #1;
    chk("nomext_ar_valid", 32'(out_valid), 0);
    chk("nomext_ar_op", 32'(aluoperation), 0);
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
